// File: rtl/ram_stream_reader.sv
// Streams a contiguous block of words out of a 1-cycle-latency single-port RAM.
// A small shift FIFO absorbs the read latency so the valid/ready stream can stall freely.
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  RSR_Clk,
  input  logic                  RSR_Reset_n,
  input  logic                  RSR_Start,
  input  logic [ADDR_WIDTH-1:0] RSR_Base_Addr,
  input  logic [ADDR_WIDTH:0]   RSR_Length,
  output logic [ADDR_WIDTH-1:0] RSR_Ram_Address,
  output logic                  RSR_Ram_Oe,
  output logic                  RSR_Ram_We,
  input  logic [DATA_WIDTH-1:0] RSR_Ram_Data,
  output logic [DATA_WIDTH-1:0] RSR_Out_Data,
  output logic                  RSR_Out_Valid,
  input  logic                  RSR_Out_Ready,
  output logic                  RSR_Out_Last,
  output logic                  RSR_Busy,
  output logic                  RSR_Done
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_wr_cnt;
  logic                  r_busy;
  logic                  r_oe;
  logic                  r_done;
  logic                  r_pipe0;
  logic                  r_pipe1;

  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [CNT_W-1:0]      r_count;

  logic [DATA_WIDTH-1:0] w_nxt_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] w_nxt_vld;
  logic [FIFO_DEPTH-1:0] w_nxt_last;

  logic                  w_load;
  logic                  w_issue;
  logic                  w_done_nxt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_last_hs;
  logic                  w_more;
  logic                  w_room;
  logic [CNT_W-1:0]      w_wr_idx;
  logic [OCC_W-1:0]      w_occupancy;

  // Reads are only issued when the FIFO is guaranteed to have a slot when the word lands.
  assign w_pop       = r_fifo_vld[0] & RSR_Out_Ready;
  assign w_push      = r_pipe1;
  assign w_last_hs   = w_pop & r_fifo_last[0];
  assign w_more      = (r_issued < r_len);
  assign w_occupancy = OCC_W'(r_count) + OCC_W'(r_pipe0) + OCC_W'(r_pipe1);
  assign w_room      = (w_occupancy < OCC_W'(FIFO_DEPTH));
  assign w_wr_idx    = r_count - CNT_W'(w_pop);
  assign w_push_last = (r_wr_cnt == (r_len - LEN_W'(1)));

  always_ff @(posedge RSR_Clk) begin
    if (!RSR_Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RSR_Start) begin
          if (RSR_Length != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_issue = w_more & w_room;
        if (w_last_hs) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address generation, read-pipeline tracking and transfer bookkeeping.
  always_ff @(posedge RSR_Clk) begin
    if (!RSR_Reset_n) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_wr_cnt <= '0;
      r_busy   <= 1'b0;
      r_oe     <= 1'b0;
      r_done   <= 1'b0;
      r_pipe0  <= 1'b0;
      r_pipe1  <= 1'b0;
    end else begin
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_oe    <= (w_state_nxt == S_RUN);
      r_pipe0 <= w_load | w_issue;
      r_pipe1 <= r_pipe0;
      if (w_load) begin
        r_addr   <= RSR_Base_Addr;
        r_len    <= RSR_Length;
        r_issued <= LEN_W'(1);
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_issued <= r_issued + LEN_W'(1);
      end
      if (w_load) begin
        r_wr_cnt <= '0;
      end else if (w_push) begin
        r_wr_cnt <= r_wr_cnt + LEN_W'(1);
      end
    end
  end

  // Shift FIFO: entry 0 is always the head, so the stream outputs come straight from flops.
  always_comb begin
    w_nxt_vld  = r_fifo_vld;
    w_nxt_last = r_fifo_last;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_nxt_data[i] = r_fifo_data[i];
    end
    if (w_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_nxt_data[i] = r_fifo_data[i+1];
        w_nxt_vld[i]  = r_fifo_vld[i+1];
        w_nxt_last[i] = r_fifo_last[i+1];
      end
      w_nxt_data[FIFO_DEPTH-1] = '0;
      w_nxt_vld[FIFO_DEPTH-1]  = 1'b0;
      w_nxt_last[FIFO_DEPTH-1] = 1'b0;
    end
    if (w_push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == w_wr_idx) begin
          w_nxt_data[i] = RSR_Ram_Data;
          w_nxt_vld[i]  = 1'b1;
          w_nxt_last[i] = w_push_last;
        end
      end
    end
  end

  always_ff @(posedge RSR_Clk) begin
    if (!RSR_Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_vld  <= '0;
      r_fifo_last <= '0;
      r_count     <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= w_nxt_data[i];
      end
      r_fifo_vld  <= w_nxt_vld;
      r_fifo_last <= w_nxt_last;
      r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign RSR_Ram_Address = r_addr;
  assign RSR_Ram_Oe      = r_oe;
  assign RSR_Ram_We      = 1'b0;
  assign RSR_Out_Data    = r_fifo_data[0];
  assign RSR_Out_Valid   = r_fifo_vld[0];
  assign RSR_Out_Last    = r_fifo_last[0];
  assign RSR_Busy        = r_busy;
  assign RSR_Done        = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, scoreboard of expected words, vector table
// plus hand-written timing, zero-length, wrap, backpressure and reset sequences.
module tb_ram_stream_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] ram_addr;
  logic          ram_oe;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .RSR_Clk(clk), .RSR_Reset_n(rst_n), .RSR_Start(start),
    .RSR_Base_Addr(base_addr), .RSR_Length(length),
    .RSR_Ram_Address(ram_addr), .RSR_Ram_Oe(ram_oe), .RSR_Ram_We(ram_we),
    .RSR_Ram_Data(ram_data), .RSR_Out_Data(out_data), .RSR_Out_Valid(out_valid),
    .RSR_Out_Ready(out_ready), .RSR_Out_Last(out_last), .RSR_Busy(busy), .RSR_Done(done)
  );

  // Single-port RAM: registered read, updated only while output enable is high.
  logic [DW-1:0] mem [MEM];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) if (ram_oe) ram_q <= mem[ram_addr];
  assign ram_data = ram_q;

  typedef struct packed { logic [DW-1:0] d; logic last; } exp_t;
  exp_t q[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    bit            mid_start;
    int            exp_words;
    int            exp_dones;
  } vec_t;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_hs = 0;
  int n_done = 0;
  int first_valid_cyc = -1;
  int last_valid_cyc = -1;
  int done_cyc = -1;
  bit stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic stall_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pops, stall stability, pulse and timing capture.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("we_zero", 32'(ram_we), 32'd0);
      chk("oe_eq_busy", 32'(ram_oe), 32'(busy));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
        chk("stall_last", 32'(out_last), 32'(stall_last));
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_last && last_valid_cyc < 0) last_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got=%0h exp=none (cyc %0d)", out_data, cyc);
        end else begin
          e = q.pop_front();
          chk("data", 32'(out_data), 32'(e.d));
          chk("last", 32'(out_last), 32'(e.last));
        end
        n_hs++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(ram_addr), 32'd0);
    chk({tag, "_oe"},    32'(ram_oe), 32'd0);
    chk({tag, "_we"},    32'(ram_we), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"},  32'(out_last), 32'd0);
    chk({tag, "_data"},  32'(out_data), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
  endtask

  task automatic push_expect(input logic [AW-1:0] b, input logic [AW:0] len);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = b + AW'(i);
      q.push_back({mem[a], (i == int'(len) - 1)});
    end
  endtask

  // Starts a transfer and drives Ready per mode until the stream drains.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] len, input int mode,
                          input bit mid, output int s_edge);
    int k;
    push_expect(b, len);
    base_addr = b;
    length    = len;
    start     = 1'b1;
    tick();
    s_edge = cyc;
    start  = 1'b0;
    k = 0;
    while (k < 3000) begin
      case (mode)
        1:       out_ready = ((k % 3) == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (mid && k == 3) begin
        start     = 1'b1;
        base_addr = b + AW'(10'h155);
        length    = (AW+1)'(2);
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
      if (!busy && q.size() == 0) break;
    end
    start = 1'b0;
    if (k >= 3000) chk("xfer_timeout", 32'(k), 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int s;
    int hs0;
    int d0;
    int k;
    logic [AW-1:0] addr0;

    for (int i = 0; i < int'(MEM); i++) mem[i] = DW'(i * 37 + 11);

    vecs[0] = '{base: 10'h3FE, len: 11'd4,    mode: 0, mid_start: 1'b0, exp_words: 4,    exp_dones: 1};
    vecs[1] = '{base: 10'h100, len: 11'd8,    mode: 1, mid_start: 1'b0, exp_words: 8,    exp_dones: 1};
    vecs[2] = '{base: 10'h200, len: 11'd6,    mode: 2, mid_start: 1'b0, exp_words: 6,    exp_dones: 1};
    vecs[3] = '{base: 10'h050, len: 11'd12,   mode: 0, mid_start: 1'b1, exp_words: 12,   exp_dones: 1};
    vecs[4] = '{base: 10'h123, len: 11'd1024, mode: 0, mid_start: 1'b0, exp_words: 1024, exp_dones: 1};
    vecs[5] = '{base: 10'h3FF, len: 11'd1,    mode: 1, mid_start: 1'b0, exp_words: 1,    exp_dones: 1};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Base 0x010, length 5: cycle-exact latency, last marker and done timing.
    first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
    hs0 = n_hs; d0 = n_done;
    run_xfer(10'h010, 11'd5, 0, 1'b0, s);
    chk("lat_first_valid", 32'(first_valid_cyc), 32'(s + 2));
    chk("lat_last_valid",  32'(last_valid_cyc),  32'(s + 6));
    chk("lat_done",        32'(done_cyc),        32'(s + 7));
    chk("len5_words",      32'(n_hs - hs0),      32'd5);
    chk("len5_dones",      32'(n_done - d0),     32'd1);

    // Zero length: a lone Done pulse, no RAM activity.
    addr0 = ram_addr; d0 = n_done;
    base_addr = 10'h2AA; length = '0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("len0_done",  32'(done), 32'd1);
    chk("len0_busy",  32'(busy), 32'd0);
    chk("len0_oe",    32'(ram_oe), 32'd0);
    chk("len0_valid", 32'(out_valid), 32'd0);
    chk("len0_addr",  32'(ram_addr), 32'(addr0));
    tick();
    @(negedge clk);
    chk("len0_done_clear", 32'(done), 32'd0);
    chk("len0_done_count", 32'(n_done - d0), 32'd1);
    tick();

    for (int v = 0; v < 6; v++) begin
      hs0 = n_hs; d0 = n_done;
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].mid_start, s);
      chk($sformatf("vec%0d_words", v), 32'(n_hs - hs0), 32'(vecs[v].exp_words));
      chk($sformatf("vec%0d_dones", v), 32'(n_done - d0), 32'(vecs[v].exp_dones));
      chk($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_empty", v), 32'(q.size()), 32'd0);
    end

    // Reset after three accepted words of a ten-word transfer.
    hs0 = n_hs;
    push_expect(10'h080, 11'd10);
    base_addr = 10'h080; length = 11'd10; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 100 && (n_hs - hs0) < 3) begin
      tick();
      k++;
    end
    chk("rst_mid_words", 32'(n_hs - hs0), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_stale_valid", 32'(out_valid), 32'd0);
    end
    hs0 = n_hs; d0 = n_done;
    run_xfer(10'h0C0, 11'd3, 0, 1'b0, s);
    chk("post_rst_words", 32'(n_hs - hs0), 32'd3);
    chk("post_rst_dones", 32'(n_done - d0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Downstream consumer of the single-port simulation/feature-map RAM (1-cycle registered read, output-enable gated).
- On a start command, reads a contiguous block of words starting at a base address.
- Absorbs the RAM read latency with an internal 4-entry FIFO and presents the words as a valid/ready stream with a last marker to the CNN datapath.

Parameters:
DATA_WIDTH, 8, word width; equals RAM data width
ADDR_WIDTH, 10, RAM address width; length field is ADDR_WIDTH+1 bits
FIFO_DEPTH, 4, output buffer entries; fixed at 4, must be >= 3

Ports:
RSR_Clk  input  1  system clock, rising edge
RSR_Reset_n  input  1  synchronous active-low reset
RSR_Start  input  1  pulse: begin a transfer; ignored while busy
RSR_Base_Addr  input  ADDR_WIDTH  first word address, sampled with Start
RSR_Length  input  ADDR_WIDTH+1  word count, sampled with Start; 0 is legal
RSR_Ram_Address  output  ADDR_WIDTH  registered RAM address
RSR_Ram_Oe  output  1  RAM output enable
RSR_Ram_We  output  1  RAM write enable; constant 0
RSR_Ram_Data  input  DATA_WIDTH  RAM read data
RSR_Out_Data  output  DATA_WIDTH  stream data, FIFO head
RSR_Out_Valid  output  1  stream valid
RSR_Out_Ready  input  1  downstream ready
RSR_Out_Last  output  1  marks the final word of the transfer
RSR_Busy  output  1  transfer in progress
RSR_Done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Interface: one clock, RSR_Clk. Reset RSR_Reset_n is synchronous and active-low.
- Reset values: Address=0, Oe=0, We=0, Out_Valid=0, Out_Last=0, Out_Data=0, Busy=0, Done=0. FIFO is emptied, counters are 0, and both read pipeline stages are cleared.
- Reset mid-transfer: abort immediately; data returning from the RAM afterwards is discarded.
- FSM IDLE -> RUN -> IDLE.
  - IDLE + Start, Length>0: latch Length; load Address<=Base_Addr; issue read #0; Busy<=1, Oe<=1; go to RUN.
  - IDLE + Start, Length=0: Done=1 for the next cycle only; stay in IDLE; no RAM access.
  - RUN: Start is ignored.
  - RUN -> IDLE: on the handshake (Valid & Ready) of the word carrying Last. Next cycle Busy=0, Oe=0, Done=1 for one cycle.
- Read pipeline:
  - An issue at edge N registers the address.
  - The RAM samples it at edge N+1.
  - The word is written into the FIFO at edge N+2.
  - Track in-flight reads with a 2-stage valid shift register.
- Issue rule in RUN: issue the next read (Address<=Address+1) when both hold:
  - issued < Length;
  - fifo_count + inflight < FIFO_DEPTH, where inflight = 0..2.
  - This guarantees the FIFO never overflows and no returned word is dropped.
- Address arithmetic is modulo 2^ADDR_WIDTH. Base+Length past the top wraps to 0.
- Throughput with Ready held at 1:
  - One word per cycle in steady state.
  - Start sampled at edge N gives first Out_Valid=1 after edge N+2.
  - Last word handshakes at edge N+1+Length.
- FIFO rules:
  - Out_Data/Out_Valid/Out_Last show the FIFO head. They are stable while Valid=1 and Ready=0.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop when empty is a no-op.
- Out_Last: set on the FIFO entry whose word index equals Length-1. Index is tracked by a write counter.
- Backpressure: with Ready=0 the FIFO fills to 4. Issuing stops, the address holds, and the RAM is idle.
- Oe is 1 for the whole time Busy=1. We is always 0.
- Length = 2^ADDR_WIDTH (full memory) is supported; each address is read exactly once.

Test Plan:
- Base=0x010, Length=5, Ready=1 always: addresses 0x010..0x014 each issued once. Output is RAM[0x010..0x014] on 5 consecutive cycles starting 2 edges after Start. Last on the 5th word. Done is one cycle after the 5th handshake.
- Length=0: Done pulses once, one cycle after Start. Busy, Valid and Oe stay 0; the address is unchanged.
- Base=0x3FE, Length=4: addresses 0x3FE, 0x3FF, 0x000, 0x001. Data order matches; Last on the 4th word.
- Length=8 with Ready toggling 1,0,0,1,...: the FIFO never exceeds 4 entries. Data holds while Ready=0. All 8 words arrive in order with no duplicates or drops.
- Reset_n=0 for one cycle after 3 words are accepted from a Length=10 transfer: all outputs return to reset values. No Valid from stale RAM data. A new Start afterwards runs cleanly from its new Base.
- Start pulsed again mid-transfer with a different Base: it is ignored. The original sequence completes; a single Done.
